datamux_nch: RTL

- Parametrised successor to the 2-input terminal data arbiter.
- Merges NCH independent byte streams (ANSI-decoded serial, keyboard, future sources) into one stream for the VGA command input.
- Each channel has its own FIFO, so simultaneous valid pulses are never lost. Per-channel sticky overflow is reported on `err_ch` / `error`.
- Arbitration is selectable at run time: fixed-priority or round-robin. The output has a valid/ready handshake so the consumer can stall.

---
 rtl/datamux_pkg.sv | 13 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/datamux_nch.sv | 111 +++++++++++
 3 files changed

// File: rtl/datamux_pkg.sv
// rtl/datamux_pkg.sv - shared arbitration encodings and width helper for datamux_nch
package datamux_pkg;

  // Run-time arbitration mode encodings (value on the mode input)
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; never narrower than one bit
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead per-channel FIFO with overflow pulse
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          ovf_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Full is judged on the registered count, so a same-cycle pop never frees room for a write
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign rdata     = mem_q[rd_ptr_q];
  assign push      = wr && !full;
  assign pop       = rd && !empty;
  assign ovf_pulse = wr && full;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/datamux_nch.sv
// rtl/datamux_nch.sv - NCH-channel byte stream merger with fixed/round-robin arbitration
module datamux_nch
  import datamux_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = grant_width(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*DW-1:0] d,
  input  logic [NCH-1:0]    dv,
  input  logic              mode,
  input  logic              clr_err,
  output logic [DW-1:0]     od,
  output logic              odv,
  input  logic              odr,
  output logic [CW-1:0]     ogrant,
  output logic [NCH-1:0]    err_ch,
  output logic              error
);

  logic [DW-1:0]  head [NCH];
  logic [NCH-1:0] empty_v, full_v, ovf_v, rd_v;
  logic [CW-1:0]  grant;
  logic           load;

  logic [DW-1:0]  od_q, od_d;
  logic           odv_q, odv_d;
  logic [CW-1:0]  ogrant_q, ogrant_d;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0] err_q, err_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr        (dv[i]),
      .wdata     (d[i*DW +: DW]),
      .rd        (rd_v[i]),
      .rdata     (head[i]),
      .full      (full_v[i]),
      .empty     (empty_v[i]),
      .ovf_pulse (ovf_v[i])
    );
  end

  // Pick the first non-empty channel: from ch0 in fixed mode, from rr_ptr+1 onward in round-robin
  always_comb begin
    logic          found;
    logic [CW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (mode == MODE_RR) idx = CW'((int'(rr_ptr_q) + k) % NCH);
      else                 idx = CW'(k - 1);
      if (!found && !empty_v[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // The output register refills whenever it is free or being drained this edge
  assign load = (!odv_q || odr) && !(&empty_v);
  assign rd_v = load ? (NCH'(1) << grant) : '0;

  // Output register, round-robin pointer and sticky overflow next-state
  always_comb begin
    od_d     = od_q;
    odv_d    = odv_q;
    ogrant_d = ogrant_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      od_d     = head[grant];
      odv_d    = 1'b1;
      ogrant_d = grant;
      if (mode == MODE_RR) rr_ptr_d = grant;
    end else if (odv_q && odr) begin
      odv_d = 1'b0;
    end
    // Overflow set is applied after the clear so a simultaneous overflow wins
    err_d = (err_q & ~{NCH{clr_err}}) | ovf_v | (dv & full_v);
  end

  // Registered outputs; no combinational path from d/dv reaches od/odv
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      od_q     <= '0;
      odv_q    <= 1'b0;
      ogrant_q <= '0;
      rr_ptr_q <= CW'(NCH - 1);
      err_q    <= '0;
    end else begin
      od_q     <= od_d;
      odv_q    <= odv_d;
      ogrant_q <= ogrant_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign od     = od_q;
  assign odv    = odv_q;
  assign ogrant = ogrant_q;
  assign err_ch = err_q;
  assign error  = |err_q;

endmodule
